// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter codes, element encoding, decoder states
// and default timing constants used by the encryptor/decoder pair.
package morse_pkg;

    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] L_A = 5'd1;
    localparam logic [CODE_W-1:0] L_B = 5'd2;
    localparam logic [CODE_W-1:0] L_C = 5'd3;
    localparam logic [CODE_W-1:0] L_D = 5'd4;
    localparam logic [CODE_W-1:0] L_E = 5'd5;
    localparam logic [CODE_W-1:0] L_F = 5'd6;
    localparam logic [CODE_W-1:0] L_G = 5'd7;
    localparam logic [CODE_W-1:0] L_H = 5'd8;
    localparam logic [CODE_W-1:0] L_I = 5'd9;
    localparam logic [CODE_W-1:0] L_J = 5'd10;
    localparam logic [CODE_W-1:0] L_K = 5'd11;
    localparam logic [CODE_W-1:0] L_L = 5'd12;
    localparam logic [CODE_W-1:0] L_M = 5'd13;
    localparam logic [CODE_W-1:0] L_N = 5'd14;
    localparam logic [CODE_W-1:0] L_O = 5'd15;
    localparam logic [CODE_W-1:0] L_P = 5'd16;
    localparam logic [CODE_W-1:0] L_Q = 5'd17;
    localparam logic [CODE_W-1:0] L_R = 5'd18;
    localparam logic [CODE_W-1:0] L_S = 5'd19;
    localparam logic [CODE_W-1:0] L_T = 5'd20;
    localparam logic [CODE_W-1:0] L_U = 5'd21;
    localparam logic [CODE_W-1:0] L_V = 5'd22;
    localparam logic [CODE_W-1:0] L_W = 5'd23;
    localparam logic [CODE_W-1:0] L_X = 5'd24;
    localparam logic [CODE_W-1:0] L_Y = 5'd25;
    localparam logic [CODE_W-1:0] L_Z = 5'd26;

    localparam logic ELEM_DOT  = 1'b0;
    localparam logic ELEM_DASH = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2
    } state_e;

    localparam int DOT_MAX_DEF    = 1;
    localparam int DASH_MAX_DEF   = 4;
    localparam int LETTER_GAP_DEF = 3;
    localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/morse_lut.sv
// Combinational map from (element count, MSB-first dot/dash pattern) to
// letter code; hit=0 for any combination that is not a letter.
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0]        elem_cnt,
    input  logic [3:0]        pattern,
    output logic [CODE_W-1:0] code,
    output logic              hit
);

    always_comb begin
        code = '0;
        hit  = 1'b1;
        // Unused upper pattern bits are always zero because the pattern
        // register is cleared at the start of each letter.
        case ({elem_cnt, pattern})
            7'b001_0000: code = L_E;
            7'b001_0001: code = L_T;
            7'b010_0001: code = L_A;
            7'b010_0000: code = L_I;
            7'b010_0011: code = L_M;
            7'b010_0010: code = L_N;
            7'b011_0100: code = L_D;
            7'b011_0110: code = L_G;
            7'b011_0101: code = L_K;
            7'b011_0111: code = L_O;
            7'b011_0010: code = L_R;
            7'b011_0000: code = L_S;
            7'b011_0001: code = L_U;
            7'b011_0011: code = L_W;
            7'b100_1000: code = L_B;
            7'b100_1010: code = L_C;
            7'b100_0010: code = L_F;
            7'b100_0000: code = L_H;
            7'b100_0111: code = L_J;
            7'b100_0100: code = L_L;
            7'b100_0110: code = L_P;
            7'b100_1101: code = L_Q;
            7'b100_0001: code = L_V;
            7'b100_1001: code = L_X;
            7'b100_1011: code = L_Y;
            7'b100_1100: code = L_Z;
            default:     hit  = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Serial Morse receiver: measures mark/space run lengths, rebuilds the
// dot/dash pattern of each letter and emits its code with a VALID pulse.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int DOT_MAX    = DOT_MAX_DEF,
    parameter int DASH_MAX   = DASH_MAX_DEF,
    parameter int LETTER_GAP = LETTER_GAP_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IN,
    output logic [CODE_W-1:0] OUT,
    output logic              VALID,
    output logic              ERR,
    output state_e            state_dbg
);

    localparam logic [CNT_W-1:0] RUN_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] DASH_LIM = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(LETTER_GAP);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        pat_q, pat_d;
    logic              serr_q, serr_d;
    logic [CODE_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [CODE_W-1:0] lut_code;
    logic              lut_hit;
    logic              elem;

    morse_lut u_lut (
        .elem_cnt (cnt_q),
        .pattern  (pat_q),
        .code     (lut_code),
        .hit      (lut_hit)
    );

    assign elem = (run_q > DOT_LIM) ? ELEM_DASH : ELEM_DOT;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        serr_d  = serr_q;
        out_d   = out_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (IN) begin
                    state_d = S_MARK;
                    run_d   = RUN_ONE;
                end
            end
            S_MARK: begin
                if (IN) begin
                    if (run_q != RUN_MAX) run_d = run_q + RUN_ONE;
                end else begin
                    if (run_q > DASH_LIM || cnt_q == 3'd4) begin
                        serr_d = 1'b1;
                    end else begin
                        pat_d = {pat_q[2:0], elem};
                        cnt_d = cnt_q + 3'd1;
                    end
                    state_d = S_SPACE;
                    run_d   = RUN_ONE;
                end
            end
            S_SPACE: begin
                if (run_q >= GAP_LIM) begin
                    valid_d = 1'b1;
                    err_d   = serr_q | ~lut_hit;
                    out_d   = (serr_q | ~lut_hit) ? '0 : lut_code;
                    cnt_d   = '0;
                    pat_d   = '0;
                    serr_d  = 1'b0;
                    // A mark arriving on the closing sample opens the next letter.
                    state_d = IN ? S_MARK : S_IDLE;
                    run_d   = IN ? RUN_ONE : '0;
                end else if (IN) begin
                    state_d = S_MARK;
                    run_d   = RUN_ONE;
                end else begin
                    run_d = run_q + RUN_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            run_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            serr_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            serr_q  <= serr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign OUT       = out_q;
    assign VALID     = valid_q;
    assign ERR       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: serial streams in, letter events captured
// at the falling edge and compared with hand-derived codes.
module tb_morse_decoder;
  import morse_pkg::*;

  typedef struct {
    logic [4:0] out;
    logic       err;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_bit = 1'b0;
  logic [4:0] out_w;
  logic       valid_w;
  logic       err_w;
  state_e     state_w;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  last_drive_cyc = 0;
  bit  mon_en = 1'b0;
  ev_t got_q[$];

  string morse_tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                            "....", "..", ".---", "-.-", ".-..", "--", "-.",
                            "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                            "...-", ".--", "-..-", "-.--", "--.."};

  morse_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .IN        (in_bit),
    .OUT       (out_w),
    .VALID     (valid_w),
    .ERR       (err_w),
    .state_dbg (state_w)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor: records every VALID pulse, ERR must be low otherwise
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_w === 1'b1) begin
        got_q.push_back('{out_w, err_w, cyc});
      end else begin
        n_cmp++;
        assert (err_w === 1'b0) else begin
          n_bad++;
          $error("FAIL err_idle: observed %0b expected 0 at cycle %0d", err_w, cyc);
        end
      end
    end
  end

  // driver tasks
  task automatic chk(input string tag, input int observed, input int expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    in_bit = b;
    last_drive_cyc = cyc;
  endtask

  task automatic mark(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic space(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  // encryptor-like stream: dot=1, dash=3 highs, final dash stretched by one
  task automatic send_letter(input string s);
    int  n;
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      n = (c == "-") ? 3 : 1;
      if (c == "-" && i == s.len() - 1) n = 4;
      mark(n);
      if (i != s.len() - 1) space(1);
    end
    space(3);
  endtask

  task automatic expect_pop(input string tag, input int eo, input int ee, output int ev_cyc);
    ev_t e;
    ev_cyc = -1;
    chk({tag, "_present"}, int'(got_q.size() > 0), 1);
    if (got_q.size() > 0) begin
      e = got_q.pop_front();
      ev_cyc = e.cyc;
      chk({tag, "_out"}, int'(e.out), eo);
      chk({tag, "_err"}, int'(e.err), ee);
    end
  endtask

  task automatic expect_empty(input string tag);
    chk(tag, got_q.size(), 0);
    got_q.delete();
  endtask

  initial begin
    int t0;
    int ev_c;

    // reset state
    in_bit = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", int'(out_w), 0);
    chk("rst_valid", int'(valid_w), 0);
    chk("rst_err", int'(err_w), 0);
    chk("rst_state", int'(state_w), int'(S_IDLE));
    rst = 1'b0;
    mon_en = 1'b1;

    // A with latency measurement
    mark(1); space(1); mark(3);
    send_bit(1'b0);
    t0 = last_drive_cyc;
    space(2);
    space(4);
    expect_pop("a", 1, 0, ev_c);
    chk("a_latency", ev_c - t0, 4);
    expect_empty("a_single");

    // J with stretched final dash, then with plain 3-cycle final dash
    mark(1); space(1); mark(3); space(1); mark(3); space(1); mark(4); space(3);
    space(3);
    expect_pop("j_stretch", 10, 0, ev_c);
    mark(1); space(1); mark(3); space(1); mark(3); space(1); mark(3); space(3);
    space(3);
    expect_pop("j_plain", 10, 0, ev_c);
    expect_empty("j_single");

    // I with an internal low run of 2, then E immediately after 3 lows
    mark(1); space(2); mark(1); space(3);
    mark(1); space(3);
    space(3);
    expect_pop("i_first", 9, 0, ev_c);
    expect_pop("e_second", 5, 0, ev_c);
    expect_empty("ie_single");

    // five elements -> error
    for (int i = 0; i < 4; i++) begin mark(1); space(1); end
    mark(1); space(3);
    space(3);
    expect_pop("five_dots", 0, 1, ev_c);
    expect_empty("five_single");

    // over-long mark -> error
    mark(6); space(3);
    space(3);
    expect_pop("long_mark", 0, 1, ev_c);
    expect_empty("long_single");

    // reset mid-letter discards partial letter
    mark(1); space(1); mark(1);
    @(negedge clk);
    rst = 1'b1;
    in_bit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", int'(state_w), int'(S_IDLE));
    space(6);
    expect_empty("midrst_none");
    mark(3); space(3);
    space(3);
    expect_pop("t_after_rst", 20, 0, ev_c);
    expect_empty("t_single");

    // stuck high saturates, no output until release, then error
    mark(20);
    chk("stuck_state", int'(state_w), int'(S_MARK));
    chk("stuck_none", got_q.size(), 0);
    space(3);
    space(3);
    expect_pop("stuck_release", 0, 1, ev_c);
    expect_empty("stuck_single");

    // loopback-style stream of all 26 letters with exactly 3 lows between
    for (int k = 0; k < 26; k++) send_letter(morse_tab[k]);
    space(5);
    chk("loop_count", got_q.size(), 26);
    for (int k = 0; k < 26; k++) begin
      expect_pop($sformatf("loop_%0d", k + 1), k + 1, 0, ev_c);
    end
    expect_empty("loop_tail");

    // long idle low run produces nothing
    space(10);
    expect_empty("idle_none");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
